// File: rtl/i2s_audio_pkg.sv
// Shared constants and sample type for the WM8731 I2S audio back end.
package i2s_audio_pkg;
  localparam int unsigned PH_MAX    = 383;
  localparam int unsigned BCK_DIV   = 12;
  localparam int unsigned SLOTS     = 32;
  localparam int          PULSE_W   = 4096;
  localparam int unsigned ADC_FIRST = 1;
  localparam int unsigned ADC_LAST  = 16;

  typedef logic signed [15:0] sample_t;
endpackage

// File: rtl/sound_mixer.sv
// Combinational mixer: four +/-PULSE_W pulse lines plus offset-binary PCM scaled by 64.
module sound_mixer
  import i2s_audio_pkg::*;
(
  input  logic [3:0] i_pulses,
  input  logic [7:0] i_pcm,
  output sample_t    o_mix
);

  logic signed [7:0] w_p;
  sample_t           w_acc;

  always_comb begin
    w_p   = {~i_pcm[7], i_pcm[6:0]};
    w_acc = sample_t'(w_p) <<< 6;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i_pulses[i]) w_acc = w_acc + sample_t'(PULSE_W);
      else             w_acc = w_acc - sample_t'(PULSE_W);
    end
    o_mix = w_acc;
  end

endmodule

// File: rtl/i2s_audio_port.sv
// I2S master for the WM8731: 384-cycle frame, mixed mono sample on both DAC channels,
// left ADC word sliced with hysteresis into the tape input bit.
module i2s_audio_port
  import i2s_audio_pkg::*;
#(
  parameter int TAPE_THRESH = 1024
) (
  input  logic       clk18,
  input  logic       reset_in,
  input  logic [3:0] pulses,
  input  logic [7:0] pcm,
  output logic       tapein,
  output logic       oAUD_BCK,
  output logic       oAUD_DACLRCK,
  output logic       oAUD_DATA,
  output logic       oAUD_ADCLRCK,
  input  logic       iAUD_ADCDAT,
  output logic       frame_strobe
);

  localparam sample_t THR_HI = sample_t'(TAPE_THRESH);
  localparam sample_t THR_LO = sample_t'(-TAPE_THRESH);

  logic [8:0]  r_ph;
  logic [3:0]  r_sub;
  logic [4:0]  r_slot;
  sample_t     r_smp;
  logic [31:0] r_dac;
  sample_t     r_adc;
  logic        r_bck;
  logic        r_lrck;
  logic        r_data;
  logic        r_tape;
  logic        r_strobe;

  sample_t     w_mix;
  logic        w_frame_end;
  logic        w_slot_start;
  logic        w_adc_sample;
  logic        w_adc_done;

  sound_mixer u_mixer (
    .i_pulses (pulses),
    .i_pcm    (pcm),
    .o_mix    (w_mix)
  );

  always_comb begin
    w_frame_end  = (r_ph == 9'(PH_MAX));
    w_slot_start = (r_sub == '0);
    w_adc_sample = (r_sub == 4'(BCK_DIV / 2)) &&
                   (r_slot >= 5'(ADC_FIRST)) && (r_slot <= 5'(ADC_LAST));
    w_adc_done   = (r_sub == 4'(BCK_DIV - 1)) && (r_slot == 5'(ADC_LAST));
  end

  // ph, sub and slot advance together so sub/slot never need a divider.
  always_ff @(posedge clk18 or posedge reset_in) begin
    if (reset_in) begin
      r_ph   <= '0;
      r_sub  <= '0;
      r_slot <= '0;
    end else if (w_frame_end) begin
      r_ph   <= '0;
      r_sub  <= '0;
      r_slot <= '0;
    end else begin
      r_ph <= r_ph + 9'd1;
      if (r_sub == 4'(BCK_DIV - 1)) begin
        r_sub  <= '0;
        r_slot <= r_slot + 5'd1;
      end else begin
        r_sub <= r_sub + 4'd1;
      end
    end
  end

  always_ff @(posedge clk18 or posedge reset_in) begin
    if (reset_in) begin
      r_bck    <= 1'b0;
      r_lrck   <= 1'b0;
      r_strobe <= 1'b0;
      r_smp    <= '0;
    end else begin
      r_bck    <= (r_sub >= 4'(BCK_DIV / 2));
      r_lrck   <= (r_slot >= 5'(SLOTS / 2));
      r_strobe <= w_frame_end;
      if (w_frame_end) r_smp <= w_mix;
    end
  end

  // The slot-0 shift emits the previous frame's right LSB before the reload,
  // which yields the one-slot I2S delay without a separate delay stage.
  always_ff @(posedge clk18 or posedge reset_in) begin
    if (reset_in) begin
      r_dac  <= '0;
      r_data <= 1'b0;
    end else if (w_slot_start) begin
      r_data <= r_dac[31];
      if (r_ph == '0) r_dac <= {r_smp, r_smp};
      else            r_dac <= {r_dac[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk18 or posedge reset_in) begin
    if (reset_in) begin
      r_adc  <= '0;
      r_tape <= 1'b0;
    end else begin
      if (w_adc_sample) r_adc <= {r_adc[14:0], iAUD_ADCDAT};
      if (w_adc_done) begin
        if (r_adc > THR_HI)      r_tape <= 1'b1;
        else if (r_adc < THR_LO) r_tape <= 1'b0;
      end
    end
  end

  assign tapein       = r_tape;
  assign oAUD_BCK     = r_bck;
  assign oAUD_DACLRCK = r_lrck;
  assign oAUD_ADCLRCK = r_lrck;
  assign oAUD_DATA    = r_data;
  assign frame_strobe = r_strobe;

endmodule

// File: tb/tb_i2s_audio_port.sv
// Self-checking bench: per-cycle output prediction from a frame-level model of the I2S port.
module tb_i2s_audio_port;

  localparam int THR = 1024;

  logic       clk18 = 1'b0;
  logic       reset_in = 1'b0;
  logic [3:0] pulses = '0;
  logic [7:0] pcm = '0;
  logic       iAUD_ADCDAT = 1'b0;
  logic       tapein, oAUD_BCK, oAUD_DACLRCK, oAUD_DATA, oAUD_ADCLRCK, frame_strobe;

  i2s_audio_port #(.TAPE_THRESH(THR)) dut (
    .clk18        (clk18),
    .reset_in     (reset_in),
    .pulses       (pulses),
    .pcm          (pcm),
    .tapein       (tapein),
    .oAUD_BCK     (oAUD_BCK),
    .oAUD_DACLRCK (oAUD_DACLRCK),
    .oAUD_DATA    (oAUD_DATA),
    .oAUD_ADCLRCK (oAUD_ADCLRCK),
    .iAUD_ADCDAT  (iAUD_ADCDAT),
    .frame_strobe (frame_strobe)
  );

  always #5 clk18 = ~clk18;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model state: k = cycle index since reset release (cycle k has ph = k % 384).
  int unsigned  k;
  logic [15:0]  sent[$];       // sent[f] = word serialised during frame f
  logic         exp_tape;
  logic [7:0]   cur_pcm;
  logic [3:0]   cur_pulses;
  logic [15:0]  cur_adc;
  bit           toggle;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [15:0] mix_ref(input logic [7:0] pc, input logic [3:0] pu);
    int v;
    v = (int'(pc) - 128) * 64 + (int'($countones(pu)) * 2 - 4) * 4096;
    return 16'(v);
  endfunction

  function automatic logic [5:0] outs();
    return {tapein, oAUD_BCK, oAUD_DACLRCK, oAUD_DATA, oAUD_ADCLRCK, frame_strobe};
  endfunction

  function automatic logic [5:0] exp_outs();
    int unsigned q, f, p, s, sb;
    logic [15:0] w;
    logic        d;
    if (k == 0) return 6'b0;
    q  = k - 1;
    f  = q / 384;
    p  = q % 384;
    s  = p / 12;
    sb = p % 12;
    if (s == 0) begin
      if (f == 0) d = 1'b0;
      else begin
        w = sent[f - 1];
        d = w[0];
      end
    end else begin
      w = sent[f];
      d = w[(32 - s) % 16];
    end
    return {exp_tape, (sb >= 6), (s >= 16), d, (s >= 16), (p == 383)};
  endfunction

  task automatic model_reset();
    k = 0;
    sent.delete();
    sent.push_back(16'h0000);
    exp_tape = 1'b0;
  endtask

  task automatic model_edge(input int unsigned ph);
    int sw;
    if (ph == 383) sent.push_back(mix_ref(cur_pcm, cur_pulses));
    if (ph == 203) begin
      sw = int'($signed(cur_adc));
      if (sw > THR)       exp_tape = 1'b1;
      else if (sw < -THR) exp_tape = 1'b0;
    end
  endtask

  task automatic drive(input int unsigned ph);
    int unsigned s;
    s = ph / 12;
    if (toggle && ph != 383) begin
      pcm    = 8'($urandom);
      pulses = 4'($urandom);
    end else begin
      pcm    = cur_pcm;
      pulses = cur_pulses;
    end
    if (s >= 1 && s <= 16) iAUD_ADCDAT = cur_adc[16 - s];
    else                   iAUD_ADCDAT = 1'($urandom);
  endtask

  task automatic run_cycles(input int unsigned n);
    int unsigned ph;
    for (int unsigned i = 0; i < n; i++) begin
      ph = k % 384;
      drive(ph);
      @(posedge clk18);
      model_edge(ph);
      #1;
      k++;
      chk("outs", 16'(outs()), 16'(exp_outs()));
    end
  endtask

  task automatic frame(input logic [7:0] pc, input logic [3:0] pu, input logic [15:0] adc,
                       input bit tg);
    cur_pcm = pc; cur_pulses = pu; cur_adc = adc; toggle = tg;
    run_cycles(384);
  endtask

  initial begin
    cur_pcm = '0; cur_pulses = '0; cur_adc = '0; toggle = 0;
    model_reset();

    #2 reset_in = 1'b1;
    #1 chk("reset_outs", 16'(outs()), 16'h0000);
    repeat (3) begin
      @(posedge clk18); #1;
      chk("reset_hold", 16'(outs()), 16'h0000);
    end
    @(negedge clk18);
    reset_in = 1'b0;
    model_reset();
    chk("release_k0", 16'(outs()), 16'h0000);

    frame(8'h80, 4'b0000, 16'h0500, 0);   // -> C000 in frame 1, tape set
    chk("tape_set", 16'(tapein), 16'h0001);
    frame(8'hFF, 4'b1111, 16'h0100, 0);   // -> 5FC0 in frame 2, tape held
    chk("tape_hold_hi", 16'(tapein), 16'h0001);
    frame(8'($urandom), 4'($urandom), 16'hFA00, 0);
    chk("tape_clear", 16'(tapein), 16'h0000);
    frame(8'($urandom), 4'($urandom), 16'h0400, 1);   // +THR exactly: hold
    chk("tape_edge_hold_lo", 16'(tapein), 16'h0000);
    frame(8'($urandom), 4'($urandom), 16'h0401, 0);
    chk("tape_edge_set", 16'(tapein), 16'h0001);
    frame(8'($urandom), 4'($urandom), 16'hFC00, 1);   // -THR exactly: hold
    chk("tape_edge_hold_hi", 16'(tapein), 16'h0001);
    frame(8'($urandom), 4'($urandom), 16'hFBFF, 0);
    chk("tape_edge_clear", 16'(tapein), 16'h0000);
    for (int i = 0; i < 4; i++)
      frame(8'($urandom), 4'($urandom), 16'($urandom), (i % 2) == 1);

    cur_pcm = 8'($urandom); cur_pulses = 4'($urandom); toggle = 0;
    run_cycles(200);
    reset_in = 1'b1;
    #1 chk("midreset_outs", 16'(outs()), 16'h0000);
    repeat (3) begin
      @(posedge clk18); #1;
      chk("midreset_hold", 16'(outs()), 16'h0000);
    end
    @(negedge clk18);
    reset_in = 1'b0;
    model_reset();
    chk("midrelease_k0", 16'(outs()), 16'h0000);
    for (int i = 0; i < 3; i++)
      frame(8'($urandom), 4'($urandom), 16'($urandom), i == 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
